// File: rtl/bram_voice_arbiter.sv
// bram_voice_arbiter: shares the single BRAM read port among NUM_REQ voice loaders.
// Requesters are granted round-robin. Each burst streams NUM_WORDS samples to the owner's buffer
// as indexed 16-bit writes, then pulses done for that requester.
// Build option: define BRAM_ARB_ABORT_EN so that an owner dropping req mid-burst aborts its burst.
module bram_voice_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned NUM_WORDS      = 256,
    parameter int unsigned BRAM_DELAY     = 2,
    parameter int unsigned ADDR_INCREMENT = 4
) (
    input  logic                  BRAM_clk,
    input  logic                  rst,
    output logic [31:0]           BRAM_addr,
    output logic [31:0]           BRAM_din,
    input  logic [31:0]           BRAM_dout,
    output logic                  BRAM_en,
    output logic                  BRAM_rst,
    output logic [3:0]            BRAM_we,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] base_addr,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  wr_valid,
    output logic [15:0]           wr_index,
    output logic [15:0]           wr_data,
    output logic [NUM_REQ-1:0]    done
);

    localparam int unsigned      IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned      CNT_W    = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] WORDS    = CNT_W'(NUM_WORDS);
    localparam logic [15:0]      LAST_IDX = 16'(NUM_WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      last_win;
    logic [IDX_W-1:0]      winner;
    logic                  any_req;
    logic                  abort;
    logic [31:0]           base_arr [NUM_REQ];
    logic [CNT_W-1:0]      issue_cnt;
    logic [15:0]           rx_cnt;
    logic [BRAM_DELAY-1:0] en_pipe;
    logic                  unused_dout;

    // Read-only port: write side tied off; upper data half carries no sample.
    assign BRAM_din    = '0;
    assign BRAM_we     = '0;
    assign unused_dout = ^BRAM_dout[31:16];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_base
        assign base_arr[g] = base_addr[g*32 +: 32];
    end

`ifdef BRAM_ARB_ABORT_EN
    assign abort = (state == READ) && !req[owner];
`else
    assign abort = 1'b0;
`endif

    // Round-robin pick: first requesting index above the last winner, wrapping.
    always_comb begin
        int j;
        j       = 0;
        winner  = '0;
        any_req = 1'b0;
        // Walk from the farthest candidate down so the nearest one is assigned last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = int'(last_win) + k;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            if (req[IDX_W'(j)]) begin
                winner  = IDX_W'(j);
                any_req = 1'b1;
            end
        end
    end

    // Arbitration FSM, address issue and return pipeline.
    always_ff @(posedge BRAM_clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            last_win  <= IDX_W'(NUM_REQ - 1);
            issue_cnt <= '0;
            rx_cnt    <= '0;
            en_pipe   <= '0;
            BRAM_addr <= '0;
            BRAM_en   <= 1'b0;
            BRAM_rst  <= 1'b1;
            grant     <= '0;
            wr_valid  <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
            done      <= '0;
        end else begin
            BRAM_rst <= 1'b0;
            done     <= '0;
            // en_pipe mirrors BRAM_en delayed by the read latency, marking valid BRAM_dout.
            en_pipe  <= (en_pipe << 1) | BRAM_DELAY'(BRAM_en);
            wr_valid <= en_pipe[BRAM_DELAY-1];
            if (en_pipe[BRAM_DELAY-1]) begin
                wr_data  <= BRAM_dout[15:0];
                wr_index <= rx_cnt;
                rx_cnt   <= rx_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    BRAM_en <= 1'b0;
                    if (any_req) begin
                        grant     <= NUM_REQ'(1) << winner;
                        owner     <= winner;
                        BRAM_addr <= {base_arr[winner][31:2], 2'b00};
                        BRAM_en   <= 1'b1;
                        issue_cnt <= CNT_W'(1);
                        rx_cnt    <= '0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        BRAM_en  <= 1'b0;
                        en_pipe  <= '0;
                        wr_valid <= 1'b0;
                        grant    <= '0;
                        last_win <= owner;
                        state    <= IDLE;
                    end else begin
                        if (issue_cnt < WORDS) begin
                            BRAM_addr <= BRAM_addr + 32'(ADDR_INCREMENT);
                            BRAM_en   <= 1'b1;
                            issue_cnt <= issue_cnt + CNT_W'(1);
                        end else begin
                            BRAM_en <= 1'b0;
                        end
                        if (wr_valid && (wr_index == LAST_IDX)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done     <= NUM_REQ'(1) << owner;
                    grant    <= '0;
                    wr_valid <= 1'b0;
                    last_win <= owner;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bram_voice_arbiter.md
Name: bram_voice_arbiter

Overview:
- Shares the single read port of the sample BRAM among NUM_REQ voice loaders. Each loader owns a local shortint sample buffer.
- A loader raises req with a word-aligned base address. The block grants requesters round-robin and streams NUM_WORDS words to the granted loader as indexed 16-bit writes.
- It pulses done per requester when the burst is complete.
- It sits between the PS-side BRAM controller port and the per-voice oscillator buffers, and replaces each voice running its own private BRAM sequencer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_WORDS, 256, words per burst (= buffer depth)
- BRAM_DELAY, 2, BRAM read latency in cycles, address to BRAM_dout valid
- ADDR_INCREMENT, 4, byte address step per word

Ports:
- BRAM_clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock BRAM_clk
- BRAM_addr  out  32  BRAM byte address
- BRAM_din  out  32  write data (constant 0)
- BRAM_dout  in  32  read data; samples in [15:0]
- BRAM_en  out  1  BRAM enable
- BRAM_rst  out  1  BRAM reset
- BRAM_we  out  4  write enable (constant 0)
- req  in  NUM_REQ  per-requester burst request, level
- base_addr  in  NUM_REQ*32  packed base addresses; slice i belongs to requester i
- grant  out  NUM_REQ  one-hot; high for the whole burst of the owner
- wr_valid  out  1  sample write strobe
- wr_index  out  16  buffer index 0..NUM_WORDS-1
- wr_data  out  16  sample (BRAM_dout[15:0])
- done  out  NUM_REQ  one-cycle completion pulse, one-hot

Behaviour:
- Reset: BRAM_addr=0, BRAM_en=0, BRAM_we=0, BRAM_din=0, BRAM_rst=1, grant=0, wr_valid=0, wr_index=0, wr_data=0, done=0. The round-robin pointer is set so requester 0 has top priority. BRAM_rst is deasserted on the first cycle after rst falls.
- Reset mid-burst: the transfer is discarded, no done is issued, and all in-flight reads are dropped.
- States: IDLE, READ, DONE.
- IDLE, no req: BRAM_en=0.
- IDLE, any req bit high in cycle T: the winner w is the first set bit searching upward from (last winner + 1) mod NUM_REQ, with wrap. Registered at the end of T:
  - grant=onehot(w)
  - BRAM_addr=base_addr[w] with bits [1:0] forced to 0
  - BRAM_en=1, issue_cnt=1
  - next state READ
- READ, address issue:
  - While issue_cnt<NUM_WORDS: BRAM_addr+=ADDR_INCREMENT (32-bit, wraps mod 2^32), BRAM_en=1, issue_cnt++.
  - Otherwise BRAM_en=0 and BRAM_addr holds.
- READ, return pipeline: a BRAM_DELAY-deep shift register tracks BRAM_en. Its output registers wr_valid=1, wr_data=BRAM_dout[15:0], wr_index=rx_cnt, then rx_cnt++.
- Word timing: word k appears on wr_* in cycle T+2+BRAM_DELAY+k. Words arrive contiguously, with no gaps, in ascending index order.
- READ to DONE: taken in the cycle the last word (index NUM_WORDS-1) is written.
- DONE (one cycle):
  - done[w]=1, grant=0, wr_valid=0
  - last winner=w, then IDLE
  - done pulses in cycle T+3+BRAM_DELAY+NUM_WORDS.
- Request handling:
  - req is sampled only in IDLE. The requester must drop req on seeing done; req still high in IDLE is a new request (refresh).
  - Default build: req falling during READ is ignored and the burst completes.
  - Simultaneous requests are served one burst each, in round-robin order. No requester is served twice while another is waiting.
  - base_addr[w] is captured at grant; later changes do not affect the burst in progress.
- Invariants: grant is one-hot or zero; wr_valid implies grant!=0; BRAM_we=0 always.

Optional Feature:
- Macro: BRAM_ARB_ABORT_EN.
- Defined: if req[w] falls while in READ, then in the next cycle:
  - BRAM_en=0, issue stops
  - the return pipeline is flushed, with no further wr_valid for that burst
  - grant=0, done is not asserted, last winner=w
  - state returns to IDLE
- Not defined: req falling during READ is ignored and the burst runs to completion, as in Behaviour.

Test Plan (NUM_WORDS=8, BRAM_DELAY=2, BRAM model dout[15:0]=addr>>2):
- Reset, then req=4'b0001, base0=0x100:
  - grant=0001 one cycle after req; BRAM_addr steps 0x100..0x11C.
  - wr_index 0..7 carries wr_data 0x40..0x47 in consecutive cycles.
  - done[0] pulses exactly once, 13 cycles after req is first seen.
- req=4'b1111 held continuously from reset: grants occur in order 0,1,2,3,0; each burst yields exactly 8 writes; no gaps inside a burst.
- Requester 2 served, then req=4'b0101: grant goes to 0 before 2; a following grant goes to 2.
- base0=0xFFFFFFF8, req[0]: BRAM_addr goes 0xFFFFFFF8, 0xFFFFFFFC, 0x0, ... 0x14 (wrap); 8 writes.
- rst asserted at wr_index=3: next cycle all outputs hold reset values and done stays 0; a new req[1] afterwards completes normally.
- With BRAM_ARB_ABORT_EN defined, req0 dropped after 3 writes: BRAM_en=0 and grant=0 next cycle, no further wr_valid, no done[0]; a pending req1 is granted next.
